// File: rtl/relm_fifo_pkg.sv
// Shared encodings and field positions for the multi-channel ReLM FIFO port.
// Command lives in the low bits of the pop word; lock bit sits at the word MSB.
package relm_fifo_pkg;

  typedef enum logic [1:0] {
    CMD_STATUS = 2'b00,
    CMD_POP    = 2'b01,
    CMD_PEEK   = 2'b10,
    CMD_FLUSH  = 2'b11
  } cmd_e;

  localparam int CMD_LSB     = 0;
  localparam int CMD_W       = 2;
  localparam int RSP_CNT_LSB = 0;

  function automatic int lock_bit_idx(input int wd);
    return wd - 1;
  endfunction

  // Watermark field sits directly above the (WAD+1)-bit count field.
  function automatic int rsp_hw_lsb(input int wad);
    return wad + 1;
  endfunction

endpackage

// File: rtl/relm_fifo_mc_io_if.sv
// Bundled push/pop buses for all channels; slave side is the FIFO block.
interface relm_fifo_mc_io_if #(
  parameter int NCH = 2,
  parameter int WD  = 32
);
  logic [NCH*(WD+1)-1:0] push_d;
  logic [NCH-1:0]        push_retry;
  logic [NCH*(WD+1)-1:0] pop_d;
  logic [NCH*(WD+1)-1:0] pop_q;

  modport master (output push_d, output pop_d, input push_retry, input pop_q);
  modport slave  (input push_d, input pop_d, output push_retry, output pop_q);
endinterface

// File: rtl/relm_dpmem.sv
// Simple dual-port RAM, registered read, write-first when addresses collide.
// Write-first lets a push into an empty FIFO become the head one cycle later.
module relm_dpmem #(
  parameter int WAD = 4,
  parameter int WD  = 32
) (
  input  logic           clk,
  input  logic           i_we,
  input  logic [WAD-1:0] i_wa,
  input  logic [WD-1:0]  i_wd,
  input  logic [WAD-1:0] i_ra,
  output logic [WD-1:0]  o_rd
);
  logic [WD-1:0] r_mem [2**WAD];
  logic [WD-1:0] r_rd;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
    r_rd <= (i_we && (i_wa == i_ra)) ? i_wd : r_mem[i_ra];
  end

  assign o_rd = r_rd;
endmodule

// File: rtl/relm_fifo_ch.sv
// One FIFO channel: pointers, sticky lock, combinational pop_q/push_retry; 0-cycle response.
// Optional high-water register under RELM_FIFO_WATERMARK_EN.
module relm_fifo_ch
  import relm_fifo_pkg::*;
#(
  parameter int WAD = 4,
  parameter int WD  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [WD:0] i_push_d,
  output logic        o_push_retry,
  input  logic [WD:0] i_pop_d,
  output logic [WD:0] o_pop_q
);
  localparam int             LOCK_IDX = lock_bit_idx(WD);
  localparam logic [WAD:0]   FULL_CNT = {1'b1, {WAD{1'b0}}};
  localparam logic [WAD:0]   PTR_ONE  = {{WAD{1'b0}}, 1'b1};

  logic [WAD:0]  r_wa, r_ra, r_lock_dummy_n;
  logic          r_lock;
  logic [WAD:0]  w_wa_nxt, w_ra_nxt, w_cnt;
  logic [WD-1:0] w_head, w_status, w_cnt_pl;
  logic          w_push_vld, w_pop_vld, w_empty, w_full;
  logic          w_do_pop, w_flush, w_push_ok;
  logic [WD-1:0] w_push_dat, w_pop_word;
  cmd_e          w_cmd;
  logic          w_unused;

  assign w_push_vld = i_push_d[WD];
  assign w_push_dat = i_push_d[WD-1:0];
  assign w_pop_vld  = i_pop_d[WD];
  assign w_pop_word = i_pop_d[WD-1:0];
  assign w_unused   = ^{w_pop_word[WD-2:CMD_LSB+CMD_W], r_lock_dummy_n};
  assign r_lock_dummy_n = '0;

  assign w_cnt    = r_wa - r_ra;
  assign w_empty  = (w_cnt == '0);
  assign w_cmd    = r_lock ? CMD_POP : cmd_e'(w_pop_word[CMD_LSB +: CMD_W]);
  assign w_do_pop = w_pop_vld && (w_cmd == CMD_POP) && !w_empty;
  assign w_flush  = w_pop_vld && (w_cmd == CMD_FLUSH);
  // A pop freeing a slot this cycle lets a push on a full FIFO through.
  assign w_full       = (w_cnt == FULL_CNT) && !w_do_pop;
  assign o_push_retry = w_push_vld && (w_full || w_flush);
  assign w_push_ok    = w_push_vld && !w_full && !w_flush;

  assign w_wa_nxt = w_push_ok ? r_wa + PTR_ONE : r_wa;
  assign w_ra_nxt = w_flush ? r_wa : (w_do_pop ? r_ra + PTR_ONE : r_ra);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa   <= '0;
      r_ra   <= '0;
      r_lock <= 1'b0;
    end else begin
      r_wa <= w_wa_nxt;
      r_ra <= w_ra_nxt;
      if (w_pop_vld && w_pop_word[LOCK_IDX]) r_lock <= 1'b1;
    end
  end

`ifdef RELM_FIFO_WATERMARK_EN
  localparam int HW_LSB = rsp_hw_lsb(WAD);
  logic [WAD:0] r_hw, w_cnt_nxt;

  assign w_cnt_nxt = w_wa_nxt - w_ra_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_hw <= '0;
    else if (w_flush)          r_hw <= '0;
    else if (w_cnt_nxt > r_hw) r_hw <= w_cnt_nxt;
  end
`endif

  always_comb begin
    w_status = '0;
    w_status[RSP_CNT_LSB +: WAD+1] = w_cnt;
`ifdef RELM_FIFO_WATERMARK_EN
    w_status[HW_LSB +: WAD+1] = r_hw;
`endif
    w_cnt_pl = '0;
    w_cnt_pl[RSP_CNT_LSB +: WAD+1] = w_cnt;
  end

  always_comb begin
    o_pop_q = '0;
    if (w_pop_vld) begin
      case (w_cmd)
        CMD_STATUS:        o_pop_q = {1'b0, w_status};
        CMD_POP, CMD_PEEK: o_pop_q = w_empty ? {1'b1, {WD{1'b0}}} : {1'b0, w_head};
        CMD_FLUSH:         o_pop_q = {1'b0, w_cnt_pl};
        default:           o_pop_q = '0;
      endcase
    end
  end

  relm_dpmem #(.WAD(WAD), .WD(WD)) u_mem (
    .clk  (clk),
    .i_we (w_push_ok),
    .i_wa (r_wa[WAD-1:0]),
    .i_wd (w_push_dat),
    .i_ra (w_ra_nxt[WAD-1:0]),
    .o_rd (w_head)
  );
endmodule

// File: rtl/relm_fifo_mc_io.sv
// NCH independent ReLM FIFO channels behind push/pop buses; responses are same-cycle.
// Optional per-channel watermark under RELM_FIFO_WATERMARK_EN; push_retry is the only backpressure.
module relm_fifo_mc_io
  import relm_fifo_pkg::*;
#(
  parameter int NCH = 2,
  parameter int WAD = 4,
  parameter int WD  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  relm_fifo_mc_io_if.slave   bus
);
  logic [NCH-1:0]        w_push_retry;
  logic [NCH*(WD+1)-1:0] w_pop_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    relm_fifo_ch #(.WAD(WAD), .WD(WD)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push_d     (bus.push_d[c*(WD+1) +: WD+1]),
      .o_push_retry (w_push_retry[c]),
      .i_pop_d      (bus.pop_d[c*(WD+1) +: WD+1]),
      .o_pop_q      (w_pop_q[c*(WD+1) +: WD+1])
    );
  end

  assign bus.push_retry = w_push_retry;
  assign bus.pop_q      = w_pop_q;
endmodule

// File: tb/tb_relm_fifo_mc_io.sv
// Directed bench for relm_fifo_mc_io with NCH=2, WAD=2 (depth 4); immediate-assertion checks.
module tb_relm_fifo_mc_io;
  import relm_fifo_pkg::*;

  localparam int NCH = 2;
  localparam int WAD = 2;
  localparam int WD  = 32;
  localparam int W   = WD + 1;

  localparam logic [W-1:0] RETRY = {1'b1, {WD{1'b0}}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  relm_fifo_mc_io_if #(.NCH(NCH), .WD(WD)) bus ();

  relm_fifo_mc_io #(.NCH(NCH), .WAD(WAD), .WD(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [W-1:0] ok(input logic [WD-1:0] d);
    return {1'b0, d};
  endfunction

  // Expected watermark field contents for a given peak count.
  function automatic logic [WD-1:0] hwf(input int n);
    logic [WD-1:0] v;
    v = WD'(n) << (WAD + 1);
`ifndef RELM_FIFO_WATERMARK_EN
    v = '0;
`endif
    return v;
  endfunction

  function automatic logic [W-1:0] q(input int ch);
    return bus.pop_q[ch*W +: W];
  endfunction

  function automatic logic [W-1:0] rty(input int ch);
    return {{WD{1'b0}}, bus.push_retry[ch]};
  endfunction

  task automatic idle();
    bus.push_d = '0;
    bus.pop_d  = '0;
  endtask

  task automatic push(input int ch, input logic [WD-1:0] d);
    bus.push_d[ch*W +: W] = {1'b1, d};
  endtask

  task automatic req(input int ch, input logic lock, input cmd_e cmd);
    logic [WD-1:0] w;
    w = '0;
    w[WD-1] = lock;
    w[1:0]  = cmd;
    bus.pop_d[ch*W +: W] = {1'b1, w};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WD-1:0] exp_tail [4];
    exp_tail = '{32'h22, 32'h33, 32'h44, 32'h99};
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state; first push accepted alongside status/pop probes
    req(0, 1'b0, CMD_STATUS); req(1, 1'b0, CMD_POP); push(0, 32'h11); #1;
    chk("rst_status_ch0", q(0), ok(0));
    chk("rst_pop_ch1", q(1), RETRY);
    chk("rst_push_retry", {{(W-NCH){1'b0}}, bus.push_retry}, '0);
    tick();
    for (int i = 2; i <= 4; i++) begin
      push(0, WD'(32'h11 * i)); tick();
    end

    push(0, 32'h55); req(0, 1'b0, CMD_STATUS); #1;
    chk("full_retry", rty(0), 1);
    chk("status_full", q(0), ok(4));
    tick();

    req(0, 1'b0, CMD_PEEK); #1;
    chk("peek_head", q(0), ok(32'h11));
    tick();
    req(0, 1'b0, CMD_STATUS); #1;
    chk("status_after_peek", q(0), ok(4));
    tick();

    for (int i = 1; i <= 4; i++) begin
      req(0, 1'b0, CMD_POP); #1;
      chk("pop_order", q(0), ok(WD'(32'h11 * i)));
      tick();
    end
    req(0, 1'b0, CMD_POP); #1;
    chk("pop_empty", q(0), RETRY);
    tick();

    // Refill, then push+pop on a full FIFO
    for (int i = 1; i <= 4; i++) begin
      push(0, WD'(32'h11 * i)); tick();
    end
    push(0, 32'h99); req(0, 1'b0, CMD_POP); #1;
    chk("full_pushpop_retry", rty(0), 0);
    chk("full_pushpop_data", q(0), ok(32'h11));
    tick();
    req(0, 1'b0, CMD_STATUS); #1;
    chk("status_after_pushpop", q(0), ok(4));
    tick();
    for (int i = 0; i < 4; i++) begin
      req(0, 1'b0, CMD_POP); #1;
      chk("tail_order", q(0), ok(exp_tail[i]));
      tick();
    end

    // Push into empty channel 1 with simultaneous pop
    push(1, 32'hAB); req(1, 1'b0, CMD_POP); #1;
    chk("empty_pushpop_pop", q(1), RETRY);
    chk("empty_pushpop_retry", rty(1), 0);
    tick();
    req(1, 1'b0, CMD_POP); #1;
    chk("empty_pushpop_next", q(1), ok(32'hAB));
    tick();

    // Flush with simultaneous push
    push(0, 32'h01); push(1, 32'hC1); tick();
    push(0, 32'h02); tick();
    push(0, 32'h03); tick();
    push(0, 32'h77); req(0, 1'b0, CMD_FLUSH); #1;
    chk("flush_count", q(0), ok(3));
    chk("flush_push_retry", rty(0), 1);
    tick();
    push(0, 32'h77); req(0, 1'b0, CMD_STATUS); #1;
    chk("status_after_flush", q(0), ok(0));
    chk("retry_push_accept", rty(0), 0);
    tick();
    req(1, 1'b0, CMD_STATUS); #1;
    chk("ch1_unaffected_status", q(1), ok(32'd1 | hwf(1)));
    tick();
    req(1, 1'b0, CMD_POP); #1;
    chk("ch1_unaffected_pop", q(1), ok(32'hC1));
    tick();

    // Lock: STATUS with lock bit, then STATUS behaves as POP
    push(0, 32'hA1); tick();
    push(0, 32'hA2); tick();
    req(0, 1'b1, CMD_STATUS); #1;
    chk("lock_req_status", q(0), ok(32'd3 | hwf(3)));
    tick();
    req(0, 1'b0, CMD_STATUS); #1;
    chk("locked_pop0", q(0), ok(32'h77));
    tick();
    req(0, 1'b0, CMD_STATUS); #1;
    chk("locked_pop1", q(0), ok(32'hA1));
    tick();
    req(0, 1'b0, CMD_STATUS); push(0, 32'hEE); #1;
    chk("locked_pop2", q(0), ok(32'hA2));
    rst_n = 1'b0; #1;
    chk("async_rst_status", q(0), ok(0));
    chk("async_rst_retry", rty(0), 0);
    req(1, 1'b0, CMD_POP); #1;
    chk("async_rst_ch1_pop", q(1), RETRY);
    tick();
    rst_n = 1'b1;

    // Post-reset traffic and watermark after draining a peak of 3
    for (int i = 1; i <= 3; i++) begin
      push(0, WD'(32'hB0 + i)); tick();
    end
    for (int i = 1; i <= 3; i++) begin
      req(0, 1'b0, CMD_POP); #1;
      chk("post_rst_pop", q(0), ok(WD'(32'hB0 + i)));
      tick();
    end
    req(0, 1'b0, CMD_STATUS); #1;
    chk("watermark_status", q(0), ok(hwf(3)));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/relm_fifo_mc_io.md
Name: relm_fifo_mc_io

Overview:
- Multi-channel successor to the single FIFO I/O port on the ReLM push/pop buses.
- NCH independent FIFOs, each 2^WAD deep.
- Each channel has one push port and one pop port in the standard {valid, data} (WD+1)-bit bus format.
- Pop-side command word selects status, pop, peek or flush, with a sticky lock-to-pop mode.
- Sits beside the PE ring; channel c push/pop ports connect to ReLM push/pop index c.

Parameters:
- NCH, 2, number of channels (≥1)
- WAD, 4, log2 FIFO depth per channel (≥1)
- WD, 32, data width; must satisfy WD ≥ 2*(WAD+1)+1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- push_d  in  NCH*(WD+1)  per channel {valid, data}; channel c at [c*(WD+1)+:WD+1]
- push_retry  out  NCH  per channel; 1 = push not accepted this cycle, PE retries
- pop_d  in  NCH*(WD+1)  per channel {valid, command word}
- pop_q  out  NCH*(WD+1)  per channel {retry, payload}

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0, all read/write pointers, count, lock and watermark clear immediately.
  - Every channel reads empty right away: push_retry=0, and a POP/PEEK in flight returns retry.
  - Memory contents are not cleared.
- Command word: cmd = pop_d[1:0] (00 STATUS, 01 POP, 10 PEEK, 11 FLUSH); lock bit = pop_d[WD-1].
- Lock: a valid request with the lock bit set makes that channel's lock sticky from the next cycle. Once locked, every valid request is treated as POP. Only reset clears the lock.
- Pop response is combinational, same cycle as the request. Head data comes from a read port prefetched at ra_next, so it is valid the cycle after any pointer change.
- pop_d valid=0: pop_q = 0, no state change.
- STATUS: pop_q = {0, zero-extended count}; count is WAD+1 bits, 0..2^WAD.
- POP:
  - empty: pop_q = {1, 0}, no change.
  - otherwise: pop_q = {0, head}; the head is removed at the clock edge.
- PEEK: as POP, but the head is not removed.
- FLUSH:
  - pop_q = {0, count before flush}.
  - At the edge, read pointer := write pointer and count := 0.
  - A push in the same cycle is refused (push_retry=1); nothing is lost.
- Push: accepted when push_d valid and not full.
  - Full = (count == 2^WAD) and no POP removing this cycle, so a push and a pop on a full FIFO both succeed.
  - push_retry = valid & full (after the pop exception above) | (valid & FLUSH this cycle).
  - Because retry depends on valid, a non-pushing PE never sees a retry.
- Push into empty with a simultaneous POP: the POP returns retry; the data becomes visible the next cycle.
- Pointers are WAD+1 bits and wrap modulo 2^(WAD+1). Count = wa - ra. There is no overflow or underflow path.
- Channels are fully independent; there is no cross-channel arbitration.

Optional Feature:
- Macro: RELM_FIFO_WATERMARK_EN.
- Defined: per channel, a high-water register holds the maximum count since reset or the last FLUSH.
  - It updates at each edge to max(hw, next count).
  - STATUS payload bits [2*(WAD+1)-1:WAD+1] = hw; FLUSH resets hw to 0.
- Undefined: those STATUS bits read 0 and the register is absent.

Decomposition:
- Package relm_fifo_pkg holds:
  - command encodings CMD_STATUS, CMD_POP, CMD_PEEK, CMD_FLUSH
  - command field position (bits 1:0)
  - lock bit index function of WD
  - response field offsets for count and watermark
- Natural sub-module relm_fifo_ch: one channel with its own relm_dpmem (WAD, WD), pointers, lock, watermark, and combinational pop_q/push_retry.
- Top level is a generate loop over NCH plus bus slicing only.

Test Plan:
- After reset, NCH=2, WAD=2: STATUS on channel 0 -> pop_q=0. POP on channel 1 -> pop_q={1,0}. push_retry=0.
- Push 0x11, 0x22, 0x33, 0x44 into channel 0 -> fifth push 0x55 has push_retry=1. STATUS -> 4. PEEK -> 0x11 and count stays 4. Four POPs -> 0x11, 0x22, 0x33, 0x44, then POP retry=1.
- Full channel 0 with simultaneous push 0x99 and POP -> push_retry=0 and pop returns 0x11. Next STATUS -> 4, and the tail is 0x99.
- Push into empty channel 1 with POP in the same cycle -> POP retry=1. POP next cycle -> {0, pushed value}.
- Three entries in channel 0, then FLUSH with simultaneous push 0x77 -> pop_q={0,3}, push_retry=1. Next STATUS -> 0. Retried push of 0x77 is accepted. Channel 1 is unaffected throughout.
- Request with lock bit set and cmd=STATUS, then STATUS requests -> each returns head data and pops. Assert rst_n=0 mid-stream -> immediate empty and lock cleared. With RELM_FIFO_WATERMARK_EN, peak 3 then drain -> STATUS watermark field = 3.
